// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the ROM byte address,
// latches the returned word into the IF/ID register and handles branch redirects,
// user-trap entry/return and stalls.
// Optional build macro: FETCH_EBREAK_HALT_EN (halt fetch after latching an ebreak).
module fetch_unit #(
   parameter int unsigned       PC_W      = 16,
   parameter logic [PC_W-1:0]   RESET_PC  = 16'h0000,
   parameter logic [31:0]       NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] pc,
   input  logic [31:0]     instr_in,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            trap_req,
   input  logic [PC_W-1:0] trap_vector,
   input  logic            trap_ret,
   input  logic [PC_W-1:0] epc,
   output logic            trap_ack,
   output logic [PC_W-1:0] saved_pc,
   output logic            in_handler,
   output logic [31:0]     if_instr,
   output logic [PC_W-1:0] if_pc,
   output logic            if_valid,
   output logic            halted
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   typedef enum logic {
      MODE_NORMAL  = 1'b0,
      MODE_HANDLER = 1'b1
   } mode_t;

   mode_t           mode_q, mode_d;
   logic [PC_W-1:0] pc_d;
   logic [31:0]     if_instr_d;
   logic [PC_W-1:0] if_pc_d;
   logic            if_valid_d;
   logic [PC_W-1:0] saved_pc_d;
   logic            trap_ack_d;

`ifdef FETCH_EBREAK_HALT_EN
   localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

   typedef enum logic {
      FETCH_RUN  = 1'b0,
      FETCH_HALT = 1'b1
   } fetch_t;

   fetch_t fetch_q, fetch_d;
   logic   halt_q;

   // Halt-state register; only reset leaves HALT.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_q <= FETCH_RUN;
         halt_q  <= 1'b0;
      end else begin
         fetch_q <= fetch_d;
         halt_q  <= (fetch_d == FETCH_HALT);
      end
   end

   assign halted = halt_q;
`else
   assign halted = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= MODE_NORMAL;
         pc       <= RESET_PC;
         if_instr <= NOP_INSTR;
         if_pc    <= '0;
         if_valid <= 1'b0;
         saved_pc <= '0;
         trap_ack <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         pc       <= pc_d;
         if_instr <= if_instr_d;
         if_pc    <= if_pc_d;
         if_valid <= if_valid_d;
         saved_pc <= saved_pc_d;
         trap_ack <= trap_ack_d;
      end
   end

   assign in_handler = (mode_q == MODE_HANDLER);

   // Next-state selection: trap > uret > branch > stall > sequential fetch.
   always_comb begin
      mode_d     = mode_q;
      pc_d       = pc;
      if_instr_d = if_instr;
      if_pc_d    = if_pc;
      if_valid_d = if_valid;
      saved_pc_d = saved_pc;
      trap_ack_d = 1'b0;
`ifdef FETCH_EBREAK_HALT_EN
      fetch_d    = fetch_q;
      if (fetch_q == FETCH_HALT) begin
         // Frozen: latch holds, but no longer presents a valid instruction.
         if_valid_d = 1'b0;
      end else
`endif
      if (trap_req && (mode_q == MODE_NORMAL)) begin
         mode_d     = MODE_HANDLER;
         saved_pc_d = pc;
         trap_ack_d = 1'b1;
         pc_d       = {trap_vector[PC_W-1:2], 2'b00};
         if_instr_d = NOP_INSTR;
         if_pc_d    = pc;
         if_valid_d = 1'b0;
      end else if (trap_ret && (mode_q == MODE_HANDLER)) begin
         mode_d     = MODE_NORMAL;
         pc_d       = {epc[PC_W-1:2], 2'b00};
         if_instr_d = NOP_INSTR;
         if_pc_d    = pc;
         if_valid_d = 1'b0;
      end else if (branch_taken) begin
         pc_d       = {branch_target[PC_W-1:2], 2'b00};
         if_instr_d = NOP_INSTR;
         if_pc_d    = pc;
         if_valid_d = 1'b0;
      end else if (!stall) begin
         pc_d       = pc + PC_STEP;
         if_instr_d = instr_in;
         if_pc_d    = pc;
         if_valid_d = 1'b1;
`ifdef FETCH_EBREAK_HALT_EN
         if (instr_in == EBREAK_INSTR) begin
            fetch_d = FETCH_HALT;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. The ROM model returns
// {16'hABCD, pc} for every address, or an ebreak word when forced.
module tb_fetch_unit;

   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] EBREAK = 32'h00100073;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc;
   logic [31:0] instr_in;
   logic        stall, branch_taken, trap_req, trap_ret;
   logic [15:0] branch_target, trap_vector, epc;
   logic        trap_ack, in_handler, if_valid, halted;
   logic [15:0] saved_pc, if_pc;
   logic [31:0] if_instr;
   logic        rom_ebreak;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .pc(pc), .instr_in(instr_in), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .trap_req(trap_req), .trap_vector(trap_vector), .trap_ret(trap_ret),
      .epc(epc), .trap_ack(trap_ack), .saved_pc(saved_pc), .in_handler(in_handler),
      .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   // Combinational ROM model.
   always_comb instr_in = rom_ebreak ? EBREAK : {16'hABCD, pc};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 0; branch_taken = 0; trap_req = 0; trap_ret = 0;
      branch_target = '0; trap_vector = '0; epc = '0; rom_ebreak = 0;
      step(); step();
      rst = 1'b0;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h exp 0000", pc); end
      checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h exp %h", if_instr, NOP); end
      checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL reset_if_pc: got %h exp 0000", if_pc); end
      checks++; if ({if_valid, trap_ack, in_handler, halted} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {if_valid, trap_ack, in_handler, halted}); end
      checks++; if (saved_pc !== 16'h0000) begin errors++; $display("FAIL reset_saved_pc: got %h exp 0000", saved_pc); end
   endtask

   task automatic test_sequential();
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++; if (pc !== 16'(4*k)) begin errors++; $display("FAIL seq_pc[%0d]: got %h exp %h", k, pc, 16'(4*k)); end
         checks++; if (if_pc !== 16'(4*(k-1)) || if_valid !== 1'b1) begin errors++; $display("FAIL seq_latch[%0d]: got pc %h v %b exp %h v 1", k, if_pc, if_valid, 16'(4*(k-1))); end
         checks++; if (if_instr !== {16'hABCD, 16'(4*(k-1))}) begin errors++; $display("FAIL seq_instr[%0d]: got %h", k, if_instr); end
      end
   endtask

   task automatic test_stall();
      do_reset(); step(); step();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (pc !== 16'h0008 || if_pc !== 16'h0004 || if_valid !== 1'b1 || if_instr !== 32'hABCD0004) begin
            errors++; $display("FAIL stall_hold[%0d]: got pc %h if_pc %h v %b instr %h exp 0008 0004 1 abcd0004", k, pc, if_pc, if_valid, if_instr); end
      end
      stall = 1'b0;
      step();
      checks++; if (pc !== 16'h000C || if_pc !== 16'h0008 || if_instr !== 32'hABCD0008) begin errors++; $display("FAIL stall_release: got pc %h if_pc %h instr %h exp 000c 0008 abcd0008", pc, if_pc, if_instr); end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 5; k++) step();
      checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL branch_setup: got %h exp 0020", pc); end
      branch_taken = 1'b1; branch_target = 16'h0023;
      step();
      branch_taken = 1'b0;
      checks++; if (pc !== 16'h0020 || if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 16'h0020) begin
         errors++; $display("FAIL branch_redirect: got pc %h v %b instr %h if_pc %h exp 0020 0 00000013 0020", pc, if_valid, if_instr, if_pc); end
      step();
      checks++; if (pc !== 16'h0024 || if_pc !== 16'h0020 || if_valid !== 1'b1 || if_instr !== 32'hABCD0020) begin
         errors++; $display("FAIL branch_target_fetch: got pc %h if_pc %h v %b instr %h", pc, if_pc, if_valid, if_instr); end
      // Branch overrides stall.
      stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0041;
      step();
      stall = 1'b0; branch_taken = 1'b0;
      checks++; if (pc !== 16'h0040 || if_valid !== 1'b0 || if_pc !== 16'h0024) begin errors++; $display("FAIL branch_over_stall: got pc %h v %b if_pc %h exp 0040 0 0024", pc, if_valid, if_pc); end
   endtask

   task automatic test_trap();
      do_reset();
      for (int k = 0; k < 6; k++) step();
      trap_req = 1'b1; trap_vector = 16'h0100;
      step();
      checks++; if (trap_ack !== 1'b1 || saved_pc !== 16'h0018 || pc !== 16'h0100 || in_handler !== 1'b1 || if_valid !== 1'b0) begin
         errors++; $display("FAIL trap_entry: got ack %b saved %h pc %h ih %b v %b exp 1 0018 0100 1 0", trap_ack, saved_pc, pc, in_handler, if_valid); end
      // Held request while in handler is ignored; sequential fetch proceeds.
      step();
      trap_req = 1'b0;
      checks++; if (trap_ack !== 1'b0 || pc !== 16'h0104 || saved_pc !== 16'h0018 || in_handler !== 1'b1 || if_valid !== 1'b1) begin
         errors++; $display("FAIL trap_ignored: got ack %b pc %h saved %h ih %b v %b exp 0 0104 0018 1 1", trap_ack, pc, saved_pc, in_handler, if_valid); end
      trap_ret = 1'b1; epc = 16'h001C;
      step();
      trap_ret = 1'b0;
      checks++; if (pc !== 16'h001C || in_handler !== 1'b0 || if_valid !== 1'b0 || if_pc !== 16'h0104) begin
         errors++; $display("FAIL trap_return: got pc %h ih %b v %b if_pc %h exp 001c 0 0 0104", pc, in_handler, if_valid, if_pc); end
   endtask

   task automatic test_same_edge();
      trap_req = 1'b1; branch_taken = 1'b1; stall = 1'b1;
      trap_vector = 16'h0203; branch_target = 16'h0080;
      step();
      trap_req = 1'b0; branch_taken = 1'b0; stall = 1'b0;
      checks++; if (pc !== 16'h0200 || trap_ack !== 1'b1 || saved_pc !== 16'h001C || in_handler !== 1'b1) begin
         errors++; $display("FAIL same_edge_trap: got pc %h ack %b saved %h ih %b exp 0200 1 001c 1", pc, trap_ack, saved_pc, in_handler); end
      step();
      checks++; if (pc !== 16'h0204 || trap_ack !== 1'b0) begin errors++; $display("FAIL same_edge_after: got pc %h ack %b exp 0204 0", pc, trap_ack); end
      trap_ret = 1'b1; epc = 16'h0010;
      step();
      checks++; if (pc !== 16'h0010 || in_handler !== 1'b0) begin errors++; $display("FAIL ret_accept: got pc %h ih %b exp 0010 0", pc, in_handler); end
      // uret outside handler is ignored.
      step();
      trap_ret = 1'b0;
      checks++; if (pc !== 16'h0014 || if_pc !== 16'h0010 || if_valid !== 1'b1 || in_handler !== 1'b0) begin
         errors++; $display("FAIL ret_ignored: got pc %h if_pc %h v %b ih %b exp 0014 0010 1 0", pc, if_pc, if_valid, in_handler); end
   endtask

   task automatic test_reset_mid();
      trap_req = 1'b1; trap_vector = 16'h0100;
      step();
      trap_req = 1'b0;
      step();
      checks++; if (pc !== 16'h0104 || in_handler !== 1'b1) begin errors++; $display("FAIL mid_setup: got pc %h ih %b exp 0104 1", pc, in_handler); end
      rst = 1'b1; branch_taken = 1'b1; branch_target = 16'h0300; trap_ret = 1'b1; epc = 16'h0040;
      step();
      rst = 1'b0; branch_taken = 1'b0; trap_ret = 1'b0;
      checks++; if (pc !== 16'h0000 || if_instr !== NOP || if_pc !== 16'h0000 || saved_pc !== 16'h0000 ||
                    {if_valid, trap_ack, in_handler, halted} !== 4'b0000) begin
         errors++; $display("FAIL mid_reset: got pc %h instr %h if_pc %h saved %h flags %b", pc, if_instr, if_pc, saved_pc, {if_valid, trap_ack, in_handler, halted}); end
   endtask

`ifdef FETCH_EBREAK_HALT_EN
   task automatic test_ebreak_halt();
      step();
      rom_ebreak = 1'b1;
      step();
      rom_ebreak = 1'b0;
      checks++; if (halted !== 1'b1 || if_instr !== EBREAK || if_valid !== 1'b1 || if_pc !== 16'h0004) begin
         errors++; $display("FAIL ebreak_latch: got h %b instr %h v %b if_pc %h", halted, if_instr, if_valid, if_pc); end
      branch_taken = 1'b1; branch_target = 16'h0080; trap_req = 1'b1; trap_vector = 16'h0100;
      step(); step();
      branch_taken = 1'b0; trap_req = 1'b0;
      checks++; if (halted !== 1'b1 || pc !== 16'h0008 || if_valid !== 1'b0 || trap_ack !== 1'b0 || in_handler !== 1'b0) begin
         errors++; $display("FAIL ebreak_frozen: got h %b pc %h v %b ack %b ih %b exp 1 0008 0 0 0", halted, pc, if_valid, trap_ack, in_handler); end
      do_reset();
      checks++; if (halted !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL ebreak_reset: got h %b pc %h", halted, pc); end
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_trap();
      test_same_edge();
      test_reset_mid();
`ifdef FETCH_EBREAK_HALT_EN
      test_ebreak_halt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction ROM. Owns the program counter and drives the ROM byte address. Registers the returned word into the IF/ID latch with a valid flag. Handles branch/jump redirects, user-trap entry to the trap vector, `uret` return, and pipeline stalls.

Parameters:
- PC_W, 16, program counter / ROM address width in bits
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 32'h00000013, word placed in if_instr when squashed or in reset (addi x0,x0,0)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc  out  PC_W  byte address to instruction ROM (ROM indexes pc>>2)
- instr_in  in  32  word returned combinationally by ROM for current pc
- stall  in  1  hold PC and IF/ID latch
- branch_taken  in  1  redirect to branch_target (branch/jal/jalr resolved)
- branch_target  in  PC_W  redirect byte address
- trap_req  in  1  enter user trap handler
- trap_vector  in  PC_W  handler address (utvec CSR)
- trap_ret  in  1  uret executing
- epc  in  PC_W  return address (uepc CSR)
- trap_ack  out  1  1-cycle pulse: trap accepted this edge
- saved_pc  out  PC_W  PC captured at trap entry, written to uepc by CSR file
- in_handler  out  1  1 while executing trap handler
- if_instr  out  32  IF/ID instruction
- if_pc  out  PC_W  IF/ID PC of if_instr
- if_valid  out  1  if_instr is a real, non-squashed instruction
- halted  out  1  see Optional Feature; constant 0 when compiled out

Behaviour:
- All state updates on the rising edge of clk; rst is sampled synchronously.
- Reset values: pc=RESET_PC, if_instr=NOP_INSTR, if_pc=0, if_valid=0, trap_ack=0, saved_pc=0, in_handler=0, halted=0.
- rst asserted mid-operation overrides every other input that cycle.
- ROM path is combinational: instr_in corresponds to the current pc in the same cycle. Fetch-to-latch latency is one edge.
- Per-edge priority, highest first: rst > trap_req (accepted) > trap_ret (accepted) > branch_taken > stall > sequential.
- Sequential (no event, no stall): if_instr<=instr_in, if_pc<=pc, if_valid<=1, pc<=pc+4. Addition wraps modulo 2^PC_W.
- stall alone: pc, if_instr, if_pc and if_valid all hold.
- Redirects (branch, trap, ret) override stall. On any redirect: if_instr<=NOP_INSTR, if_valid<=0 (wrong-path fetch squashed), if_pc<=pc.
- branch_taken: pc<=branch_target with bits[1:0] forced to 0.
- trap_req is accepted only when in_handler=0. On accept:
  - saved_pc<=pc (the next unissued instruction)
  - pc<=trap_vector (bits[1:0] cleared)
  - in_handler<=1
  - trap_ack=1 for exactly that cycle
- trap_req while in_handler=1 is ignored: no ack, no redirect. A lower-priority input applies that cycle. The requester must hold trap_req until acknowledged.
- trap_ret is accepted only when in_handler=1: pc<=epc (bits[1:0] cleared), in_handler<=0. trap_ret while in_handler=0 is ignored; a lower-priority input applies.
- trap_req and branch_taken on the same edge: trap wins, and the branch is lost.
- Trap mode states: NORMAL (in_handler=0) -> HANDLER on accepted trap_req. HANDLER -> NORMAL on accepted trap_ret. Only rst otherwise forces NORMAL.
- Fetch states: RUN and HALT (HALT exists only with the optional feature).

Optional Feature:
FETCH_EBREAK_HALT_EN
- Defined:
  - When a valid latch would capture instr_in==32'h00100073 (ebreak), the edge latches it normally, sets halted<=1 and enters HALT.
  - In HALT, pc and the latch freeze and subsequent edges present if_valid=0.
  - Only rst leaves HALT. trap_req, trap_ret and branch_taken are ignored while halted.
- Undefined: ebreak is fetched like any other word, halted is tied 0, and there is no HALT state.

Test Plan:
- Reset then 4 free-running edges -> pc = 0,4,8,12,16. if_pc = 0,4,8,12 with if_valid=1. if_instr matches ROM words 0..3.
- stall high for 3 edges at pc=8 -> pc stays 8 and the latch is unchanged. Release -> pc=12, if_pc=8.
- branch_taken with branch_target=16'h0023 at pc=32 -> pc=0x20 next edge, if_valid=0 and if_instr=0x00000013, then if_pc=0x20 valid.
- trap_req with trap_vector=0x0100 at pc=24 -> trap_ack pulse, saved_pc=24, pc=0x100, in_handler=1. A second trap_req is ignored. trap_ret with epc=28 -> pc=28, in_handler=0.
- Same-edge trap_req + branch_taken + stall -> trap taken, pc=trap_vector, branch dropped. trap_ret while in_handler=0 -> pc continues pc+4.
- rst asserted while in_handler=1 and pc=0x104 -> all outputs at reset values next edge. With FETCH_EBREAK_HALT_EN, fetching 0x00100073 -> halted=1 and pc frozen until rst.
